uart_alu_ctrl: RTL and testbench
================================

Name: uart_alu_ctrl

Overview:
Sequencer between the UART receiver, the ALU and the UART transmitter. It collects three received bytes in order: operand A, operand B, then opcode. It presents them to the combinational ALU, captures the result and hands it to the transmitter with a start pulse. It also handles parity-flagged bytes, inter-byte timeouts and bytes that arrive while busy.

Parameters:
- DATA_WIDTH, 8, width of received bytes, operands and ALU result.
- OP_WIDTH, 6, opcode width; taken from rx_data[OP_WIDTH-1:0].
- TIMEOUT_CYCLES, 1000000, clk cycles allowed between accepted bytes of one sequence; 0 disables the timeout.
- TIMER_WIDTH, $clog2(TIMEOUT_CYCLES+1), timeout counter width.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  DATA_WIDTH  byte from receiver; valid when rx_done=1.
- rx_done  input  1  one-cycle pulse, byte available.
- rx_error  input  1  parity/stop error for the byte flagged by rx_done; sampled only with rx_done.
- alu_result  input  DATA_WIDTH  combinational ALU output driven from op_a/op_b/op_code.
- tx_done  input  1  one-cycle pulse, transmitter finished the frame.
- op_a  output  DATA_WIDTH  registered operand A.
- op_b  output  DATA_WIDTH  registered operand B.
- op_code  output  OP_WIDTH  registered opcode.
- tx_data  output  DATA_WIDTH  registered byte to transmit.
- tx_start  output  1  one-cycle pulse to start transmission.
- busy  output  1  high in EXEC, SEND, WAIT_TX.
- drop_pulse  output  1  one-cycle pulse, valid byte ignored because busy.
- err_timeout  output  1  one-cycle pulse, partial sequence aborted.
- err_parity  output  1  one-cycle pulse, errored byte discarded and sequence restarted.

Behaviour:
- All outputs and state are registered. On reset (synchronous, in any state, including mid-transmission): state=WAIT_A, all outputs 0, timer 0.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX (one-hot or binary, implementer's choice).
- WAIT_A: on rx_done with rx_error=0, set op_a<=rx_data, clear the timer, go to WAIT_B.
- WAIT_B: on good rx_done, set op_b<=rx_data, clear the timer, go to WAIT_OP.
- WAIT_OP: on good rx_done, set op_code<=rx_data[OP_WIDTH-1:0], go to EXEC.
- EXEC: one cycle only; the ALU sees the new op_code this cycle. Set tx_data<=alu_result, go to SEND.
- SEND: tx_start=1 for exactly this cycle, go to WAIT_TX.
- WAIT_TX: hold until tx_done=1, then go to WAIT_A. tx_start stays 0.
- Latency: opcode rx_done at cycle N gives EXEC at N+1 and tx_start high at N+2.
- Parity error: rx_done with rx_error=1 in WAIT_A/WAIT_B/WAIT_OP:
  - err_parity pulses next cycle;
  - the byte is discarded and the state goes to WAIT_A;
  - op_a/op_b/op_code keep their previous values.
- Busy drop: rx_done in EXEC/SEND/WAIT_TX pulses drop_pulse next cycle (regardless of rx_error). There is no state or register change.
- Timeout:
  - The timer counts each cycle in WAIT_B and WAIT_OP. It is held at 0 in all other states.
  - When the timer equals TIMEOUT_CYCLES-1 with no rx_done, go to WAIT_A, pulse err_timeout and clear the timer.
  - If rx_done coincides with expiry, rx_done wins and no timeout is raised.
  - With TIMEOUT_CYCLES=0 the timer never expires. The timer saturates and never wraps.
- Operand registers change only on accepted bytes and are never cleared except by reset.
- Error/drop pulses are mutually exclusive per cycle and never last more than one cycle.

Test Plan:
- Reset, send 0x05, 0x03, opcode 0x20 (ADD, ALU model) -> op_a=0x05, op_b=0x03, op_code=0x20. tx_data=0x08 and tx_start single pulse 2 cycles after the third rx_done. busy high until tx_done. Then back in WAIT_A.
- TIMEOUT_CYCLES=16: send 0x11, then idle 16 cycles -> err_timeout pulses once, state WAIT_A. Then send 0xAA, 0x01, 0x22 -> op_a=0xAA, full transaction completes.
- Send 0x07 then 0x09 with rx_error=1 -> err_parity pulse, op_b unchanged (0). Next good bytes 0x01, 0x02, op 0x20 -> tx_data=0x03.
- While in WAIT_TX, pulse rx_done with 0x55 -> drop_pulse one cycle, op_a unchanged. After tx_done, 0x55 is not used as operand A.
- Assert reset during WAIT_TX -> next cycle all outputs 0 and state WAIT_A. A late tx_done after reset has no effect.
- TIMEOUT_CYCLES=16: rx_done for the second byte arrives exactly on the expiry cycle -> byte accepted, no err_timeout, state WAIT_OP.

Source files
------------

// File: rtl/uart_alu_ctrl.sv
// Sequences UART bytes (operand A, operand B, opcode) into the ALU and returns the result to the UART transmitter.
// Opcode byte to tx_start is two cycles; bytes arriving while busy are dropped with a pulse.
module uart_alu_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int OP_WIDTH       = 6,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TIMER_WIDTH    = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_done,
  input  logic                  rx_error,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  tx_done,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [OP_WIDTH-1:0]   op_code,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  output logic                  busy,
  output logic                  drop_pulse,
  output logic                  err_timeout,
  output logic                  err_parity
);

  // A zero-length timer is illegal, so a disabled timeout still keeps one bit.
  localparam int              TW         = (TIMER_WIDTH < 1) ? 1 : TIMER_WIDTH;
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]   TIMER_MAX  = '1;

  typedef enum logic [2:0] {
    S_WAIT_A,
    S_WAIT_B,
    S_WAIT_OP,
    S_EXEC,
    S_SEND,
    S_WAIT_TX
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic [TW-1:0] timer_inc;
  logic          good_byte;
  logic          bad_byte;
  logic          expired;
  logic          ld_a;
  logic          ld_b;
  logic          ld_op;
  logic          ld_tx;
  logic          drop_nxt;
  logic          parity_nxt;
  logic          timeout_nxt;

  assign good_byte = rx_done && !rx_error;
  assign bad_byte  = rx_done && rx_error;
  assign expired   = TIMEOUT_EN && (timer == TIMER_LAST);
  assign timer_inc = (timer == TIMER_MAX) ? timer : timer + TW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT_A;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // The timer is zero everywhere except while waiting for operand B or the opcode.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = '0;
    ld_a        = 1'b0;
    ld_b        = 1'b0;
    ld_op       = 1'b0;
    ld_tx       = 1'b0;
    drop_nxt    = 1'b0;
    parity_nxt  = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      S_WAIT_A: begin
        if (good_byte) begin
          ld_a      = 1'b1;
          state_nxt = S_WAIT_B;
        end else if (bad_byte) begin
          parity_nxt = 1'b1;
        end
      end
      S_WAIT_B: begin
        if (good_byte) begin
          ld_b      = 1'b1;
          state_nxt = S_WAIT_OP;
        end else if (bad_byte) begin
          parity_nxt = 1'b1;
          state_nxt  = S_WAIT_A;
        end else if (expired) begin
          timeout_nxt = 1'b1;
          state_nxt   = S_WAIT_A;
        end else begin
          timer_nxt = timer_inc;
        end
      end
      S_WAIT_OP: begin
        if (good_byte) begin
          ld_op     = 1'b1;
          state_nxt = S_EXEC;
        end else if (bad_byte) begin
          parity_nxt = 1'b1;
          state_nxt  = S_WAIT_A;
        end else if (expired) begin
          timeout_nxt = 1'b1;
          state_nxt   = S_WAIT_A;
        end else begin
          timer_nxt = timer_inc;
        end
      end
      S_EXEC: begin
        ld_tx     = 1'b1;
        drop_nxt  = rx_done;
        state_nxt = S_SEND;
      end
      S_SEND: begin
        drop_nxt  = rx_done;
        state_nxt = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        drop_nxt = rx_done;
        if (tx_done) begin
          state_nxt = S_WAIT_A;
        end
      end
      default: begin
        state_nxt = S_WAIT_A;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a        <= '0;
      op_b        <= '0;
      op_code     <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      drop_pulse  <= 1'b0;
      err_timeout <= 1'b0;
      err_parity  <= 1'b0;
    end else begin
      if (ld_a) begin
        op_a <= rx_data;
      end
      if (ld_b) begin
        op_b <= rx_data;
      end
      if (ld_op) begin
        op_code <= rx_data[OP_WIDTH-1:0];
      end
      if (ld_tx) begin
        tx_data <= alu_result;
      end
      tx_start    <= (state_nxt == S_SEND);
      busy        <= (state_nxt == S_EXEC) || (state_nxt == S_SEND) || (state_nxt == S_WAIT_TX);
      drop_pulse  <= drop_nxt;
      err_timeout <= timeout_nxt;
      err_parity  <= parity_nxt;
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl with a small behavioural ALU and a 16-cycle timeout.
module tb_uart_alu_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_done = 1'b0;
  logic       rx_error = 1'b0;
  logic [7:0] alu_result;
  logic       tx_done = 1'b0;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [5:0] op_code;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       drop_pulse;
  logic       err_timeout;
  logic       err_parity;

  int checks = 0;
  int errors = 0;

  uart_alu_ctrl #(
    .DATA_WIDTH(8),
    .OP_WIDTH(6),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .rx_error(rx_error),
    .alu_result(alu_result),
    .tx_done(tx_done),
    .op_a(op_a),
    .op_b(op_b),
    .op_code(op_code),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .busy(busy),
    .drop_pulse(drop_pulse),
    .err_timeout(err_timeout),
    .err_parity(err_parity)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (op_code)
      6'h20:   alu_result = op_a + op_b;
      6'h22:   alu_result = op_a - op_b;
      6'h24:   alu_result = op_a & op_b;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the next negedge with the byte consumed.
  task automatic send_byte(input logic [7:0] b, input logic err);
    rx_data  = b;
    rx_done  = 1'b1;
    rx_error = err;
    @(negedge clk);
    rx_done  = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({op_a, op_b, op_code, tx_data} !== 30'h0) begin
      errors++;
      $display("FAIL reset_regs got a=%h b=%h op=%h tx=%h want all 0", op_a, op_b, op_code, tx_data);
    end
    checks++;
    if ({tx_start, busy, drop_pulse, err_timeout, err_parity} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000", {tx_start, busy, drop_pulse, err_timeout, err_parity});
    end
  endtask

  task automatic test_add();
    send_byte(8'h05, 1'b0);
    checks++;
    if (op_a !== 8'h05 || busy !== 1'b0) begin
      errors++;
      $display("FAIL add_op_a got a=%h busy=%b want 05/0", op_a, busy);
    end
    send_byte(8'h03, 1'b0);
    send_byte(8'h20, 1'b0);
    // EXEC cycle
    checks++;
    if (op_b !== 8'h03 || op_code !== 6'h20 || busy !== 1'b1 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL add_exec got b=%h op=%h busy=%b start=%b want 03/20/1/0", op_b, op_code, busy, tx_start);
    end
    tick(1);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h08) begin
      errors++;
      $display("FAIL add_send got start=%b tx=%h want 1/08", tx_start, tx_data);
    end
    tick(1);
    checks++;
    if (tx_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL add_wait_tx got start=%b busy=%b want 0/1", tx_start, busy);
    end
    tick(5);
    checks++;
    if (busy !== 1'b1 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL add_hold got busy=%b start=%b want 1/0", busy, tx_start);
    end
    pulse_tx_done();
    checks++;
    if (busy !== 1'b0 || tx_data !== 8'h08) begin
      errors++;
      $display("FAIL add_done got busy=%b tx=%h want 0/08", busy, tx_data);
    end
  endtask

  task automatic test_timeout();
    logic early;
    early = 1'b0;
    send_byte(8'h11, 1'b0);
    for (int i = 0; i < 15; i++) begin
      if (err_timeout !== 1'b0) early = 1'b1;
      tick(1);
    end
    checks++;
    if (early || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got early pulse=1 want 0");
    end
    tick(1);
    checks++;
    if (err_timeout !== 1'b1 || op_a !== 8'h11) begin
      errors++;
      $display("FAIL timeout_pulse got to=%b a=%h want 1/11", err_timeout, op_a);
    end
    tick(1);
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_width got %b want 0", err_timeout);
    end
    send_byte(8'hAA, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h22, 1'b0);
    tick(1);
    checks++;
    if (op_a !== 8'hAA || op_b !== 8'h01 || tx_start !== 1'b1 || tx_data !== 8'hA9) begin
      errors++;
      $display("FAIL timeout_recover got a=%h b=%h start=%b tx=%h want AA/01/1/A9", op_a, op_b, tx_start, tx_data);
    end
    tick(2);
    pulse_tx_done();
  endtask

  task automatic test_parity();
    do_reset();
    send_byte(8'h07, 1'b0);
    send_byte(8'h09, 1'b1);
    checks++;
    if (err_parity !== 1'b1 || op_b !== 8'h00 || op_a !== 8'h07) begin
      errors++;
      $display("FAIL parity_pulse got par=%b b=%h a=%h want 1/00/07", err_parity, op_b, op_a);
    end
    tick(1);
    checks++;
    if (err_parity !== 1'b0 || drop_pulse !== 1'b0) begin
      errors++;
      $display("FAIL parity_width got par=%b drop=%b want 0/0", err_parity, drop_pulse);
    end
    send_byte(8'h01, 1'b0);
    checks++;
    if (op_a !== 8'h01) begin
      errors++;
      $display("FAIL parity_restart got a=%h want 01", op_a);
    end
    send_byte(8'h02, 1'b0);
    send_byte(8'h20, 1'b0);
    tick(1);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h03) begin
      errors++;
      $display("FAIL parity_result got start=%b tx=%h want 1/03", tx_start, tx_data);
    end
    tick(1);
  endtask

  // Entered in WAIT_TX from the previous test.
  task automatic test_busy_drop();
    send_byte(8'h55, 1'b0);
    checks++;
    if (drop_pulse !== 1'b1 || op_a !== 8'h01 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse got drop=%b a=%h busy=%b want 1/01/1", drop_pulse, op_a, busy);
    end
    tick(1);
    checks++;
    if (drop_pulse !== 1'b0) begin
      errors++;
      $display("FAIL drop_width got %b want 0", drop_pulse);
    end
    send_byte(8'h66, 1'b1);
    checks++;
    if (drop_pulse !== 1'b1 || err_parity !== 1'b0 || op_a !== 8'h01) begin
      errors++;
      $display("FAIL drop_errbyte got drop=%b par=%b a=%h want 1/0/01", drop_pulse, err_parity, op_a);
    end
    pulse_tx_done();
    send_byte(8'h04, 1'b0);
    checks++;
    if (op_a !== 8'h04) begin
      errors++;
      $display("FAIL drop_next_a got a=%h want 04", op_a);
    end
    send_byte(8'h06, 1'b0);
    send_byte(8'h24, 1'b0);
    tick(1);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h04) begin
      errors++;
      $display("FAIL drop_result got start=%b tx=%h want 1/04", tx_start, tx_data);
    end
    tick(1);
  endtask

  // Entered in WAIT_TX from the previous test.
  task automatic test_reset_wait_tx();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++;
    if ({op_a, op_b, op_code, tx_data} !== 30'h0 ||
        {tx_start, busy, drop_pulse, err_timeout, err_parity} !== 5'b0) begin
      errors++;
      $display("FAIL rst_wait_tx got a=%h b=%h op=%h tx=%h flags=%b want all 0",
               op_a, op_b, op_code, tx_data, {tx_start, busy, drop_pulse, err_timeout, err_parity});
    end
    pulse_tx_done();
    checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL rst_late_tx_done got busy=%b start=%b want 0/0", busy, tx_start);
    end
    send_byte(8'h33, 1'b0);
    checks++;
    if (op_a !== 8'h33 || drop_pulse !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_a got a=%h drop=%b want 33/0", op_a, drop_pulse);
    end
  endtask

  // Entered in WAIT_B with timer 0 from the previous test.
  task automatic test_expiry_race();
    tick(15);
    send_byte(8'h44, 1'b0);
    checks++;
    if (op_b !== 8'h44 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL race_accept got b=%h to=%b want 44/0", op_b, err_timeout);
    end
    tick(1);
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL race_no_timeout got %b want 0", err_timeout);
    end
    send_byte(8'h20, 1'b0);
    tick(1);
    checks++;
    if (op_code !== 6'h20 || tx_start !== 1'b1 || tx_data !== 8'h77) begin
      errors++;
      $display("FAIL race_wait_op got op=%h start=%b tx=%h want 20/1/77", op_code, tx_start, tx_data);
    end
    tick(1);
    pulse_tx_done();
  endtask

  initial begin
    test_reset();
    test_add();
    test_timeout();
    test_parity();
    test_busy_drop();
    test_reset_wait_tx();
    test_expiry_race();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
